// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store initiator for a byte-enabled single-port data BRAM with a one-cycle registered read.
// Optional define MISALIGN_TRAP_EN: misaligned half/word accesses return an error instead of being force-aligned.
module lsu_mem_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4096,
  localparam int ADDRWIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [3:0]           mem_byte_we,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    end else begin
      ok = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
    end
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] o;
    case (f3[1:0])
      SZ_H:    o = {off[1], 1'b0};
      SZ_W:    o = 2'b00;
      default: o = off;
    endcase
    return o;
  endfunction

  function automatic logic [3:0] lane_strobe(input logic we, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [3:0] s;
    if (we) begin
      case (f3[1:0])
        SZ_B:    s = 4'b0001 << off;
        SZ_H:    s = off[1] ? 4'b1100 : 4'b0011;
        SZ_W:    s = 4'b1111;
        default: s = 4'b0000;
      endcase
    end else begin
      s = 4'b0000;
    end
    return s;
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      SZ_B:    r = {4{w[7:0]}};
      SZ_H:    r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  // Sign extension applies only when funct3[2] is clear (LB/LH).
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      SZ_B:    r = {{(XLEN-8){~f3[2] & b[7]}}, b};
      SZ_H:    r = {{(XLEN-16){~f3[2] & h[15]}}, h};
      SZ_W:    r = word;
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  logic [1:0]           state_q,       state_d;
  logic                 we_q,          we_d;
  logic [2:0]           f3_q,          f3_d;
  logic [1:0]           off_q,         off_d;
  logic                 mem_en_q,      mem_en_d;
  logic                 mem_we_q,      mem_we_d;
  logic [ADDRWIDTH-1:0] mem_addr_q,    mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q,   mem_wdata_d;
  logic [3:0]           mem_byte_we_q, mem_byte_we_d;
  logic                 rsp_valid_q,   rsp_valid_d;
  logic [XLEN-1:0]      rsp_rdata_q,   rsp_rdata_d;
  logic                 rsp_err_q,     rsp_err_d;

  logic       legal_s;
  logic       mis_err_s;
  logic       acc_err_s;
  logic [1:0] off_eff_s;
  logic       unused_addr_s;

  assign legal_s = funct3_legal(req_we, req_funct3);

`ifdef MISALIGN_TRAP_EN
  assign mis_err_s = misaligned(req_funct3, req_addr[1:0]);
  assign off_eff_s = req_addr[1:0];
`else
  assign mis_err_s = 1'b0;
  assign off_eff_s = align_off(req_funct3, req_addr[1:0]);
`endif

  assign acc_err_s     = ~legal_s | mis_err_s;
  assign unused_addr_s = ^req_addr[XLEN-1:ADDRWIDTH];

  // Next-state and output-register computation for the IDLE/ISSUE/WAIT sequence.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    f3_d          = f3_q;
    off_d         = off_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_we_d = 4'b0000;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = {XLEN{1'b0}};
    rsp_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_err_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d       = S_ISSUE;
            we_d          = req_we;
            f3_d          = req_funct3;
            off_d         = off_eff_s;
            mem_en_d      = 1'b1;
            mem_we_d      = req_we;
            mem_addr_d    = {req_addr[ADDRWIDTH-1:2], off_eff_s};
            mem_byte_we_d = lane_strobe(req_we, req_funct3, off_eff_s);
            if (req_we) begin
              mem_wdata_d = lane_wdata(req_funct3, req_wdata);
            end else begin
              mem_wdata_d = mem_wdata_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        if (we_q) begin
          rsp_rdata_d = {XLEN{1'b0}};
        end else begin
          rsp_rdata_d = load_extend(f3_q, off_q, mem_rdata);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {ADDRWIDTH{1'b0}};
      mem_wdata_q   <= {XLEN{1'b0}};
      mem_byte_we_q <= 4'b0000;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {XLEN{1'b0}};
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_we_q <= mem_byte_we_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byte_we = mem_byte_we_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed + randomized bench for lsu_mem_if against a byte-array reference model.
// Expectations follow MISALIGN_TRAP_EN when the define is present.
module tb_lsu_mem_if;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid, req_ready, req_we;
  logic [2:0]      req_funct3;
  logic [31:0]     req_addr, req_wdata;
  logic            rsp_valid, rsp_err;
  logic [31:0]     rsp_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata, mem_rdata;
  logic [3:0]      mem_byte_we;

  lsu_mem_if #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_we(mem_byte_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int i);
    return 32'hC3A5_0000 ^ (i * 32'h0103_0507);
  endfunction

  // Byte-enabled BRAM with registered read (environment, not reference).
  logic [31:0] bram [0:1023];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) bram[i] <= pattern(i);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_byte_we[b]) bram[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= bram[mem_addr[AW-1:2]];
    end
  end

  // Reference: flat byte memory covering addresses 0..63.
  logic [7:0] ref_mem [0:63];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                       output logic [3:0] strb, output logic [31:0] mwd, output logic [31:0] maddr);
    int size, a, off;
    logic legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    a     = int'(addr[11:0]);
`ifdef MISALIGN_TRAP_EN
    err = !legal || ((a % size) != 0);
`else
    err = !legal;
    a   = a - (a % size);
`endif
    rdata = 32'd0;
    strb  = 4'd0;
    mwd   = wd;
    maddr = 32'(a);
    if (!err) begin
      off = a % 4;
      if (we) begin
        strb = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
        mwd = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
      end else begin
        for (int i = 0; i < size; i++) rdata = rdata | (32'(ref_mem[a+i]) << (8*i));
        if (!f3[2] && size < 4 && rdata[8*size-1]) rdata = rdata | (32'hFFFF_FFFF << (8*size));
      end
    end
  endtask

  logic [31:0] last_rdata, last_wd;
  logic [3:0]  last_strb;
  logic        last_err;
  int          last_en;

  // Issue one request from a negedge, observe four cycles, compare against the model.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        e_err;
    logic [31:0] e_rd, e_wd, e_addr;
    logic [3:0]  e_strb;
    int          rsp_at, n_rsp, n_en, stray, wait_cnt;
    logic [31:0] got_rd, got_wd, got_addr;
    logic [3:0]  got_strb;
    logic        got_err, got_we;
    rsp_at = 0; n_rsp = 0; n_en = 0; stray = 0; wait_cnt = 0;
    got_rd = 32'd0; got_wd = 32'd0; got_addr = 32'd0; got_strb = 4'd0; got_err = 1'b0; got_we = 1'b0;
    while (!req_ready && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    model(we, f3, addr, wd, e_err, e_rd, e_strb, e_wd, e_addr);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      end
      if (mem_en) begin
        n_en++; got_we = mem_we; got_strb = mem_byte_we; got_addr = 32'(mem_addr); got_wd = mem_wdata;
      end else if (mem_we || mem_byte_we != 4'd0) begin
        stray++;
      end
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_at == 0) rsp_at = k;
        got_rd = rsp_rdata; got_err = rsp_err;
      end
    end
    check_eq({tag, "_lat"}, 32'(rsp_at), e_err ? 32'd1 : 32'd3);
    check_eq({tag, "_nrsp"}, 32'(n_rsp), 32'd1);
    check_eq({tag, "_nen"}, 32'(n_en), e_err ? 32'd0 : 32'd1);
    check_eq({tag, "_stray"}, 32'(stray), 32'd0);
    check_eq({tag, "_err"}, 32'(got_err), 32'(e_err));
    check_eq({tag, "_rdata"}, got_rd, e_rd);
    if (!e_err) begin
      check_eq({tag, "_we"}, 32'(got_we), 32'(we));
      check_eq({tag, "_strb"}, 32'(got_strb), 32'(e_strb));
      check_eq({tag, "_addr"}, got_addr, e_addr);
      if (we) check_eq({tag, "_wdata"}, got_wd, e_wd);
    end
    last_rdata = got_rd; last_wd = got_wd; last_strb = got_strb; last_err = got_err; last_en = n_en;
  endtask

  initial begin
    logic        e_err;
    logic [31:0] e_rd, e_wd, e_addr, e_old;
    logic [3:0]  e_strb;
    int          first_acc, last_acc, n_acc, n_rsp;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    preload = 1'b1;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) begin
        e_rd = pattern(i);
        ref_mem[4*i+j] = e_rd[8*j +: 8];
      end
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_bwe", 32'(mem_byte_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check_eq("sw10_strb_c", 32'(last_strb), 32'hF);
    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'd0);
    check_eq("lw10_c", last_rdata, 32'hDEADBEEF);
    do_req("sb13", 1'b1, 3'b000, 32'h13, 32'h80);
    check_eq("sb13_strb_c", 32'(last_strb), 32'h8);
    check_eq("sb13_wd_c", last_wd, 32'h80808080);
    do_req("lb13", 1'b0, 3'b000, 32'h13, 32'd0);
    check_eq("lb13_c", last_rdata, 32'hFFFFFF80);
    do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'd0);
    check_eq("lbu13_c", last_rdata, 32'h00000080);
    do_req("sh22", 1'b1, 3'b001, 32'h22, 32'h8001);
    check_eq("sh22_strb_c", 32'(last_strb), 32'hC);
    do_req("lh22", 1'b0, 3'b001, 32'h22, 32'd0);
    check_eq("lh22_c", last_rdata, 32'hFFFF8001);
    do_req("lhu22", 1'b0, 3'b101, 32'h22, 32'd0);
    check_eq("lhu22_c", last_rdata, 32'h00008001);
    do_req("lw11", 1'b0, 3'b010, 32'h11, 32'd0);
`ifdef MISALIGN_TRAP_EN
    check_eq("lw11_err_c", 32'(last_err), 32'd1);
    check_eq("lw11_en_c", 32'(last_en), 32'd0);
`else
    check_eq("lw11_err_c", 32'(last_err), 32'd0);
    check_eq("lw11_c", last_rdata, 32'h80ADBEEF);
`endif
    do_req("ld011", 1'b0, 3'b011, 32'h10, 32'd0);
    check_eq("ld011_err_c", 32'(last_err), 32'd1);
    do_req("st100", 1'b1, 3'b100, 32'h10, 32'h12345678);
    check_eq("st100_err_c", 32'(last_err), 32'd1);
    do_req("lwhi", 1'b0, 3'b010, 32'hABCD_E010, 32'd0);
    check_eq("lwhi_c", last_rdata, 32'h80ADBEEF);

    for (int n = 0; n < 300; n++)
      do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);

    // req_valid held high: one accept every three cycles.
    model(1'b0, 3'b010, 32'h10, 32'd0, e_err, e_rd, e_strb, e_wd, e_addr);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    first_acc = -1; last_acc = -1; n_acc = 0; n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) begin
        n_rsp++;
        check_eq("b2b_data", rsp_rdata, e_rd);
      end
      if (req_ready) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_nacc", 32'(n_acc), 32'd4);
    check_eq("b2b_span", 32'(last_acc - first_acc), 32'd9);
    check_eq("b2b_nrsp", 32'(n_rsp), 32'd3);
    repeat (2) @(negedge clk);

    // Reset during ISSUE of a store: dropped, no write.
    model(1'b0, 3'b010, 32'h3C, 32'd0, e_err, e_old, e_strb, e_wd, e_addr);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3C; req_wdata = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("mid_pre_en", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_en", 32'(mem_en), 32'd0);
    check_eq("mid_we", 32'(mem_we), 32'd0);
    check_eq("mid_bwe", 32'(mem_byte_we), 32'd0);
    check_eq("mid_addr", 32'(mem_addr), 32'd0);
    check_eq("mid_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check_eq("mid_norsp", 32'(n_rsp), 32'd0);
    do_req("mid_rb", 1'b0, 3'b010, 32'h3C, 32'd0);
    check_eq("mid_rb_c", last_rdata, e_old);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
